fir_lowpass: RTL and testbench

Time-multiplexed FIR low-pass filter that sits directly downstream of `imit_signal` and consumes its `o_data` / `o_valid_data` sample stream. It uses one multiply-accumulate per clock across `TAPS` coefficients. Each output is rounded and saturated back to 16-bit Q15, then emitted with a one-cycle valid strobe to the next stage or the test bench. Samples that arrive while a computation is in progress are dropped and flagged.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_delay_line.sv | 44 ++++
 rtl/fir_lowpass.sv | 157 +++++++++++++++
 tb/tb_fir_lowpass.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, widths and default low-pass coefficients for the time-multiplexed FIR.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_TAPS   = 32;

  typedef logic signed [FIR_COEF_W-1:0] coef_arr_t [FIR_TAPS];

  // Symmetric Q15 low-pass taps; DC gain is 17760/32768.
  localparam coef_arr_t LPF_COEF = '{
    -16'sd40,   -16'sd60,   -16'sd70,   -16'sd50,
     16'sd0,     16'sd90,    16'sd220,   16'sd380,
     16'sd560,   16'sd740,   16'sd910,   16'sd1060,
     16'sd1180,  16'sd1270,  16'sd1330,  16'sd1360,
     16'sd1360,  16'sd1330,  16'sd1270,  16'sd1180,
     16'sd1060,  16'sd910,   16'sd740,   16'sd560,
     16'sd380,   16'sd220,   16'sd90,    16'sd0,
    -16'sd50,   -16'sd70,   -16'sd60,   -16'sd40
  };

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: registered write at wp (wp wraps at TAPS-1), combinational read at rp.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int DATA_W = 16,
  parameter int PTR_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic signed [DATA_W-1:0] i_wr_data,
  input  logic        [PTR_W-1:0]  i_rd_addr,
  output logic signed [DATA_W-1:0] o_rd_data,
  output logic        [PTR_W-1:0]  o_wp
);

  logic signed [DATA_W-1:0] mem_q [TAPS];
  logic signed [DATA_W-1:0] mem_d [TAPS];
  logic        [PTR_W-1:0]  wp_q, wp_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    if (i_wr_en) begin
      mem_d[wp_q] = i_wr_data;
      wp_d        = (wp_q == PTR_W'(TAPS-1)) ? '0 : wp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
      wp_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];
  assign o_wp      = wp_q;

endmodule

// File: rtl/fir_lowpass.sv
// Single-MAC FIR low-pass: one tap per clock, rounded/saturated Q15 result strobed for one cycle.
// Samples arriving mid-computation are dropped; FIR_DROP_CNT_EN adds a saturating drop counter.
module fir_lowpass
  import fir_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter logic signed [COEF_W-1:0] P_COEF [TAPS] = LPF_COEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_overrun
`ifdef FIR_DROP_CNT_EN
  ,
  output logic [15:0]              o_drop_cnt
`endif
);

  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEF_W-2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  fir_state_t               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [PTR_W-1:0]  rp_q, rp_d;
  logic        [PTR_W-1:0]  k_q, k_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic                     ready_q, ready_d;

  logic                     accept;
  logic        [PTR_W-1:0]  wp;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  rounded;

  assign accept = i_valid && (state_q != MAC);

  fir_delay_line #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (accept),
    .i_wr_data (i_data),
    .i_rd_addr (rp_q),
    .o_rd_data (rd_data),
    .o_wp      (wp)
  );

  // The final tap's product feeds the rounding directly so o_valid lands in the OUT cycle.
  always_comb begin
    prod    = rd_data * P_COEF[k_q];
    mac_sum = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    rounded = (mac_sum + RND) >>> (COEF_W-1);
  end

`ifdef FIR_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rp_d      = rp_q;
    k_d       = k_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
`ifdef FIR_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
`endif
    case (state_q)
      IDLE, OUT: begin
        if (i_valid) begin
          rp_d    = wp;
          k_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = mac_sum;
        rp_d  = (rp_q == '0) ? PTR_W'(TAPS-1) : rp_q - 1'b1;
        k_d   = k_q + 1'b1;
        if (k_q == PTR_W'(TAPS-1)) begin
          state_d = OUT;
          valid_d = 1'b1;
          if (rounded > SAT_MAX)      data_d = SAT_MAX[DATA_W-1:0];
          else if (rounded < SAT_MIN) data_d = SAT_MIN[DATA_W-1:0];
          else                        data_d = rounded[DATA_W-1:0];
        end
        if (i_valid) begin
          overrun_d = 1'b1;
`ifdef FIR_DROP_CNT_EN
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != MAC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      rp_q      <= '0;
      k_q       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ready_q   <= 1'b1;
`ifdef FIR_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rp_q      <= rp_d;
      k_q       <= k_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ready_q   <= ready_d;
`ifdef FIR_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  assign o_ready   = ready_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
`ifdef FIR_DROP_CNT_EN
  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_lowpass.sv
// Bench for fir_lowpass: convolution model feeds a scoreboard, monitor pops on each o_valid.
module tb_fir_lowpass;
  import fir_pkg::*;

  localparam coef_arr_t SAT_COEF = '{default: 16'sd32767};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] i_data = '0;
  logic i_valid = 1'b0;

  logic o_ready, o_valid, o_overrun;
  logic signed [15:0] o_data;
  logic s_ready, s_valid, s_overrun;
  logic signed [15:0] s_data;
`ifdef FIR_DROP_CNT_EN
  logic [15:0] o_drop_cnt, s_drop_cnt;
`endif

  fir_lowpass dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_overrun(o_overrun)
`ifdef FIR_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  fir_lowpass #(.P_COEF(SAT_COEF)) dut_sat (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(s_ready), .o_data(s_data), .o_valid(s_valid), .o_overrun(s_overrun)
`ifdef FIR_DROP_CNT_EN
    , .o_drop_cnt(s_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int hist [32];
  logic signed [15:0] q_def [$];
  logic signed [15:0] q_sat [$];
  int vcount = 0;
  bit prev_valid = 1'b0;
  logic signed [15:0] prev_data = '0;

  function automatic logic signed [15:0] predict(input bit sat);
    longint acc = 0;
    longint r;
    for (int k = 0; k < 32; k++)
      acc += longint'(hist[k]) * (sat ? longint'(32767) : longint'(LPF_COEF[k]));
    r = (acc + 16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic model_accept(input logic signed [15:0] x);
    for (int k = 31; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(x);
    q_def.push_back(predict(1'b0));
    q_sat.push_back(predict(1'b1));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) hist[k] = 0;
    q_def.delete();
    q_sat.delete();
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic signed [15:0] ev;
    if (!rst) begin
      if (o_valid) begin
        vcount++;
        n_cmp++;
        if (prev_valid) begin
          n_err++; $display("FAIL valid_consecutive: o_valid high two cycles running");
        end
        n_cmp++;
        if (o_ready !== 1'b1) begin
          n_err++; $display("FAIL ready_in_out: o_ready=%0b required 1", o_ready);
        end
        n_cmp++;
        if (q_def.size() == 0) begin
          n_err++; $display("FAIL unexpected_valid: o_valid with o_data=%0d, nothing expected", o_data);
        end else begin
          ev = q_def.pop_front();
          if (o_data !== ev) begin
            n_err++; $display("FAIL out_data: o_data=%0d required %0d", o_data, ev);
          end
        end
        n_cmp++;
        if (s_valid !== 1'b1 || q_sat.size() == 0) begin
          n_err++; $display("FAIL sat_valid: s_valid=%0b pending=%0d", s_valid, q_sat.size());
        end else begin
          ev = q_sat.pop_front();
          if (s_data !== ev) begin
            n_err++; $display("FAIL sat_data: s_data=%0d required %0d", s_data, ev);
          end
        end
      end else begin
        n_cmp++;
        if (o_data !== prev_data) begin
          n_err++; $display("FAIL data_hold: o_data=%0d changed without o_valid, was %0d", o_data, prev_data);
        end
      end
    end
    prev_valid = o_valid;
    prev_data  = o_data;
  end

  task automatic send(input logic signed [15:0] x, input bit push, input int gap);
    @(posedge clk); #1;
    i_data = x; i_valid = 1'b1;
    if (push) model_accept(x);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (q_def.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (q_def.size() != 0) begin
      n_err++; $display("FAIL drain: %0d outputs still pending, required 0", q_def.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_data !== 16'sd0) begin n_err++; $display("FAIL rst_data: %0d required 0", o_data); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: %0b required 0", o_valid); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: %0b required 0", o_overrun); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: %0b required 1", o_ready); end
`ifdef FIR_DROP_CNT_EN
    n_cmp++; if (o_drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop_cnt: %0d required 0", o_drop_cnt); end
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic impulse_seq();
    int n = 0;
    bit found = 1'b0;
    @(posedge clk); #1;
    i_data = 16'sh7FFF; i_valid = 1'b1;
    model_accept(16'sh7FFF);
    @(posedge clk); #1;
    i_valid = 1'b0;
    while (!found && n < 60) begin
      @(negedge clk); n++;
      if (o_valid) found = 1'b1;
    end
    n_cmp++;
    if (!found || n != 33) begin
      n_err++; $display("FAIL latency: o_valid after %0d cycles (seen=%0b) required 33", n, found);
    end
    repeat (5) @(posedge clk);
    for (int i = 0; i < 32; i++) send(16'sd0, 1'b1, 38);
    drain();
  endtask

  task automatic test_impulse();
    do_reset();
    impulse_seq();
  endtask

  task automatic test_dc();
    int sum = 0;
    logic signed [15:0] dc_exp;
    for (int k = 0; k < 32; k++) sum += int'(LPF_COEF[k]);
    dc_exp = 16'((10000 * sum + 16384) >>> 15);
    do_reset();
    for (int i = 0; i < 40; i++) send(16'sd10000, 1'b1, 38);
    drain();
    n_cmp++;
    if (o_data !== dc_exp) begin
      n_err++; $display("FAIL dc_level: o_data=%0d required %0d", o_data, dc_exp);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 33; i++) send(16'sd32767, 1'b1, 38);
    drain();
    n_cmp++;
    if (s_data !== 16'sd32767) begin
      n_err++; $display("FAIL sat_pos: s_data=%0d required 32767", s_data);
    end
    for (int i = 0; i < 33; i++) send(-16'sd32768, 1'b1, 38);
    drain();
    n_cmp++;
    if (s_data !== -16'sd32768) begin
      n_err++; $display("FAIL sat_neg: s_data=%0d required -32768", s_data);
    end
  endtask

  task automatic test_overrun();
    int vc0;
    do_reset();
    vc0 = vcount;
    @(posedge clk); #1;
    i_data = 16'sd1234; i_valid = 1'b1;
    model_accept(16'sd1234);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    i_data = -16'sd999; i_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_err++; $display("FAIL ready_in_mac: o_ready=%0b required 0", o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (40) @(posedge clk);
    drain();
    n_cmp++;
    if (o_overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_flag: o_overrun=%0b required 1", o_overrun);
    end
    n_cmp++;
    if (vcount - vc0 != 1) begin
      n_err++; $display("FAIL overrun_valid_count: %0d strobes required 1", vcount - vc0);
    end
`ifdef FIR_DROP_CNT_EN
    n_cmp++;
    if (o_drop_cnt !== 16'd1) begin
      n_err++; $display("FAIL drop_cnt: o_drop_cnt=%0d required 1", o_drop_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] x;
    do_reset();
    n_cmp++;
    if (o_overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clear: o_overrun=%0b required 0 after rst", o_overrun);
    end
    @(posedge clk); #1;
    x = 16'sd5000;
    i_data = x; i_valid = 1'b1;
    model_accept(x);
    for (int s = 0; s < 6; s++) begin
      int n = 0;
      bit found = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      while (!found && n < 60) begin
        @(negedge clk); n++;
        if (o_valid) found = 1'b1;
      end
      n_cmp++;
      if (!found || n != 33) begin
        n_err++; $display("FAIL b2b_interval: strobe %0d after %0d cycles (seen=%0b) required 33", s, n, found);
      end
      if (s < 5) begin
        x = (s % 2 == 0) ? -16'sd7000 - 16'(s * 1000) : 16'sd6000 + 16'(s * 1500);
        i_data = x; i_valid = 1'b1;
        model_accept(x);
      end
    end
    drain();
    n_cmp++;
    if (o_overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_overrun: o_overrun=%0b required 0", o_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int vc0;
    @(posedge clk); #1;
    i_data = 16'sh7FFF; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++; if (o_data !== 16'sd0) begin n_err++; $display("FAIL midrst_data: %0d required 0", o_data); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: %0b required 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: %0b required 1", o_ready); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    vc0 = vcount;
    repeat (45) @(posedge clk);
    n_cmp++;
    if (vcount != vc0) begin
      n_err++; $display("FAIL midrst_no_valid: %0d strobes after reset required 0", vcount - vc0);
    end
    impulse_seq();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
